reflet_float_mult_seq: RTL and testbench

Sequential, parametrised floating-point multiplier that supersedes the combinational float multiplier for area-constrained builds. Mantissas are multiplied by an iterative shift-add datapath, one bit per cycle, with no hardware multiplier. Operand and result formats are set by exponent and mantissa width parameters. The block sits between the reflet CPU FPU dispatch and the result writeback, with valid/ready handshakes on both sides.

---
 rtl/reflet_float_mult_seq.sv | 188 ++++++++++++++++++
 tb/tb_reflet_float_mult_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reflet_float_mult_seq.sv
// Sequential floating-point multiplier: shift-add mantissa product, one multiplier bit per cycle.
// Zero/inf/NaN operands bypass the datapath and complete one cycle after accept.
module reflet_float_mult_seq #(
  parameter int exp_size   = 8,
  parameter int mant_size  = 23,
  parameter bit round_even = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [exp_size+mant_size:0]     in1,
  input  logic [exp_size+mant_size:0]     in2,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [exp_size+mant_size:0]     mult,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [3:0]                      flags,
  output logic [2:0]                      dbg_state
);

  localparam int W  = 1 + exp_size + mant_size;
  localparam int M  = mant_size + 1;
  localparam int EW = exp_size + 2;
  localparam int CW = $clog2(M + 1);
  localparam logic [exp_size-1:0] EMAX = '1;
  localparam logic signed [EW-1:0] BIAS   = EW'(2 ** (exp_size - 1) - 1);
  localparam logic signed [EW-1:0] EMAX_S = $signed({2'b00, EMAX});
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(mant_size - 1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, and mult/flags stay stable while out_valid is high.
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_NORM, S_PACK, S_DONE} state_t;

  state_t                r_state;
  logic                  r_sign;
  logic signed [EW-1:0]  r_exp;
  logic [M-1:0]          r_ma;
  logic [M-1:0]          r_mb;
  logic [2*M-1:0]        r_acc;
  logic [CW-1:0]         r_cnt;
  logic [mant_size-1:0]  r_mant;
  logic                  r_guard;
  logic                  r_sticky;
  logic [W-1:0]          r_mult;
  logic [3:0]            r_flags;
  logic                  r_out_valid;
  logic                  r_in_ready;

  logic [exp_size-1:0]   w_e1, w_e2;
  logic [mant_size-1:0]  w_m1, w_m2;
  logic                  w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
  logic                  w_special, w_sign;
  logic [W-1:0]          w_spec_res;
  logic                  w_spec_inv;
  logic signed [EW-1:0]  w_exp_sum;
  logic [M:0]            w_add;
  logic [2*M-1:0]        w_acc_next;
  logic [2*M-2:0]        w_frac;
  logic                  w_round_up;
  logic [mant_size:0]    w_mant_rnd;
  logic signed [EW-1:0]  w_exp_rnd;

  assign w_e1    = in1[W-2:mant_size];
  assign w_e2    = in2[W-2:mant_size];
  assign w_m1    = in1[mant_size-1:0];
  assign w_m2    = in2[mant_size-1:0];
  assign w_zero1 = (w_e1 == '0);
  assign w_zero2 = (w_e2 == '0);
  assign w_inf1  = (w_e1 == EMAX) && (w_m1 == '0);
  assign w_inf2  = (w_e2 == EMAX) && (w_m2 == '0);
  assign w_nan1  = (w_e1 == EMAX) && (w_m1 != '0);
  assign w_nan2  = (w_e2 == EMAX) && (w_m2 != '0);
  assign w_special = w_zero1 | w_zero2 | w_inf1 | w_inf2 | w_nan1 | w_nan2;
  assign w_sign    = in1[W-1] ^ in2[W-1];
  assign w_exp_sum = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - BIAS;

  always_comb begin
    w_spec_inv = (w_inf1 & w_zero2) | (w_zero1 & w_inf2);
    if (w_nan1 | w_nan2 | w_spec_inv) begin
      w_spec_res = QNAN;
    end else if (w_inf1 | w_inf2) begin
      w_spec_res = {w_sign, EMAX, {mant_size{1'b0}}};
    end else begin
      w_spec_res = {w_sign, {(W - 1){1'b0}}};
    end
  end

  // Right-shifting accumulator: only the upper half ever takes an add.
  assign w_add      = {1'b0, r_acc[2*M-1:M]} + (r_mb[0] ? {1'b0, r_ma} : '0);
  assign w_acc_next = {w_add, r_acc[M-1:1]};

  // Fraction bits below the hidden one, after normalising [1,4) down to [1,2).
  assign w_frac = r_acc[2*M-1] ? r_acc[2*M-2:0] : {r_acc[2*M-3:0], 1'b0};

  assign w_round_up = round_even & r_guard & (r_sticky | r_mant[0]);
  assign w_mant_rnd = {1'b0, r_mant} + (mant_size + 1)'(w_round_up);
  assign w_exp_rnd  = r_exp + $signed({{(EW - 1){1'b0}}, w_mant_rnd[mant_size]});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mant      <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_mult      <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_sign     <= w_sign;
            if (w_special) begin
              r_mult      <= w_spec_res;
              r_flags     <= {w_spec_inv, 3'b000};
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_exp   <= w_exp_sum;
              r_ma    <= {1'b1, w_m1};
              r_mb    <= {1'b1, w_m2};
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= S_MULT;
            end
          end
        end
        S_MULT: begin
          r_acc <= w_acc_next;
          r_mb  <= {1'b0, r_mb[M-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(M - 1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_acc[2*M-1]) begin
            r_exp <= r_exp + 1'b1;
          end
          r_mant   <= w_frac[2*M-2:M];
          r_guard  <= w_frac[M-1];
          r_sticky <= |w_frac[M-2:0];
          r_state  <= S_PACK;
        end
        S_PACK: begin
          if (w_exp_rnd >= EMAX_S) begin
            r_mult  <= {r_sign, EMAX, {mant_size{1'b0}}};
            r_flags <= 4'b0101;
          end else if (w_exp_rnd <= 0) begin
            r_mult  <= {r_sign, {(W - 1){1'b0}}};
            r_flags <= 4'b0011;
          end else begin
            r_mult  <= {r_sign, w_exp_rnd[exp_size-1:0], w_mant_rnd[mant_size-1:0]};
            r_flags <= {3'b000, r_guard | r_sticky};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign mult      = r_mult;
  assign flags     = r_flags;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reflet_float_mult_seq.sv
// Bench for reflet_float_mult_seq: RNE and truncating instances driven in lockstep,
// expected results queued at drive time and compared when the products appear.
module tb_reflet_float_mult_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, in_ready_tr, out_valid_tr;
  logic [31:0] mult, mult_tr;
  logic [3:0]  flags, flags_tr;
  logic [2:0]  dbg_state, dbg_state_tr;

  logic [35:0] exp_q[$];
  logic [35:0] exp_tr_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reflet_float_mult_seq #(.exp_size(8), .mant_size(23), .round_even(1'b1)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(in_ready), .mult(mult), .out_valid(out_valid), .out_ready(out_ready),
    .flags(flags), .dbg_state(dbg_state)
  );

  reflet_float_mult_seq #(.exp_size(8), .mant_size(23), .round_even(1'b0)) dut_tr (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(in_ready_tr), .mult(mult_tr), .out_valid(out_valid_tr), .out_ready(out_ready),
    .flags(flags_tr), .dbg_state(dbg_state_tr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rne);
    logic [47:0] p;
    logic [22:0] m;
    logic [23:0] mr;
    logic        g, s, up, sg;
    int          e;
    sg = a[31] ^ b[31];
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; s = |p[22:0]; e++;
    end else begin
      m = p[45:23]; g = p[22]; s = |p[21:0];
    end
    up = rne & g & (s | m[0]);
    mr = {1'b0, m} + 24'(up);
    if (mr[23]) e++;
    if (e >= 255) return {4'b0101, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0011, sg, 31'd0};
    return {3'b000, g | s, sg, e[7:0], mr[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e_rne,
                       input logic [35:0] e_tr, input int lat_exp, input int hold);
    int lat;
    logic [35:0] e;
    exp_q.push_back(e_rne);
    exp_tr_q.push_back(e_tr);
    @(negedge clk);
    in1 = a; in2 = b; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      in_valid = (lat >= 3 && lat < 6);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (lat >= 200) check("timeout", out_valid, 1);
    check("latency", lat, lat_exp);
    check("out_valid_tr", out_valid_tr, 1);
    check("ready_busy", in_ready, 0);
    e = exp_q.pop_front();
    check("mult", mult, e[31:0]);
    check("flags", flags, e[35:32]);
    e = exp_tr_q.pop_front();
    check("mult_tr", mult_tr, e[31:0]);
    check("flags_tr", flags_tr, e[35:32]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_mult", mult, e_rne[31:0]);
      check("hold_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready", in_ready, 1);
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_mult", mult, 0);
    check("rst_flags", flags, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk) reset = 1'b1;

    do_op(32'h40A00000, 32'h41700000, {4'h0, 32'h42960000}, {4'h0, 32'h42960000}, 27, 0);
    do_op(32'hC1400000, 32'h41400000, {4'h0, 32'hC3100000}, {4'h0, 32'hC3100000}, 27, 10);
    do_op(32'h44000000, 32'h44000000, {4'h0, 32'h48800000}, {4'h0, 32'h48800000}, 27, 0);
    do_op(32'h00000000, 32'h42C80000, {4'h0, 32'h00000000}, {4'h0, 32'h00000000}, 1, 0);
    do_op(32'h7F800000, 32'h00000000, {4'h8, 32'h7FC00000}, {4'h8, 32'h7FC00000}, 1, 0);
    do_op(32'h7FC00000, 32'h3F800000, {4'h0, 32'h7FC00000}, {4'h0, 32'h7FC00000}, 1, 0);
    do_op(32'hFF800000, 32'h40000000, {4'h0, 32'hFF800000}, {4'h0, 32'hFF800000}, 1, 0);
    do_op(32'h00000001, 32'h3F800000, {4'h0, 32'h00000000}, {4'h0, 32'h00000000}, 1, 0);
    do_op(32'h7F000000, 32'h40000000, {4'h5, 32'h7F800000}, {4'h5, 32'h7F800000}, 27, 0);
    do_op(32'h00800000, 32'h00800000, {4'h3, 32'h00000000}, {4'h3, 32'h00000000}, 27, 0);
    do_op(32'h3F800001, 32'h3F800001, {4'h1, 32'h3F800002}, {4'h1, 32'h3F800002}, 27, 0);
    do_op(32'h3FC00000, 32'h3F800001, {4'h1, 32'h3FC00002}, {4'h1, 32'h3FC00001}, 27, 0);
    do_op(32'h3F800003, 32'h3FC00000, {4'h1, 32'h3FC00004}, {4'h1, 32'h3FC00004}, 27, 0);

    // Abandon an operation mid-MULT with an asynchronous reset.
    @(negedge clk);
    in1 = 32'h40A00000; in2 = 32'h41700000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_mult", mult, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk) reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("arst_no_output", out_valid, 0);
    do_op(32'h40A00000, 32'h41700000, {4'h0, 32'h42960000}, {4'h0, 32'h42960000}, 27, 0);

    for (int k = 0; k < 8; k++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      do_op(a, b, ref_mul(a, b, 1'b1), ref_mul(a, b, 1'b0), 27, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
